// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// seven_segment_capture: rebuilds per-digit nibbles and decimal points from a
// scanned active-low seven-segment bus. Revision: 1.0
// ============================================================================
module seven_segment_capture #(
  parameter int NUM_SEGMENTS = 4,
  parameter int CLK_PER      = 10,
  parameter int SETTLE_NS    = 200
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_SEGMENTS-1:0]     anode,
  input  logic [7:0]                  cathode,
  output logic [NUM_SEGMENTS*4-1:0]   encoded,
  output logic [NUM_SEGMENTS-1:0]     digit_point,
  output logic                        frame_valid,
  output logic                        frame_error,
  output logic [7:0]                  error_count
);

  localparam int SETTLE_RAW    = (SETTLE_NS + CLK_PER - 1) / CLK_PER;
  localparam int SETTLE_CYCLES = (SETTLE_RAW < 1) ? 1 : SETTLE_RAW;
  localparam int CNT_W         = $clog2(SETTLE_CYCLES + 1);
  localparam int BUS_W         = NUM_SEGMENTS + 8;

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic [NUM_SEGMENTS-1:0]     an_m_q, an_m_d, an_s_q, an_s_d;
  logic [7:0]                  ca_m_q, ca_m_d, ca_s_q, ca_s_d;
  logic [BUS_W-1:0]            prev_q, prev_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NUM_SEGMENTS-1:0]     mask_q, mask_d;
  logic                        err_q, err_d;
  logic [NUM_SEGMENTS*4-1:0]   buf_q, buf_d;
  logic [NUM_SEGMENTS-1:0]     buf_dp_q, buf_dp_d;
  logic [NUM_SEGMENTS*4-1:0]   encoded_q, encoded_d;
  logic [NUM_SEGMENTS-1:0]     digit_point_q, digit_point_d;
  logic                        frame_valid_q, frame_valid_d;
  logic                        frame_error_q, frame_error_d;
  logic [7:0]                  error_count_q, error_count_d;

  logic                        changed;
  logic [NUM_SEGMENTS-1:0]     sel;
  logic                        sel_single;
  logic [4:0]                  dec;

  // Returns {valid, nibble}; unknown patterns give nibble 0 with valid low.
  function automatic logic [4:0] decode_seg(input logic [6:0] seg);
    case (seg)
      7'h40: decode_seg = 5'h10;
      7'h79: decode_seg = 5'h11;
      7'h24: decode_seg = 5'h12;
      7'h30: decode_seg = 5'h13;
      7'h19: decode_seg = 5'h14;
      7'h12: decode_seg = 5'h15;
      7'h02: decode_seg = 5'h16;
      7'h78: decode_seg = 5'h17;
      7'h00: decode_seg = 5'h18;
      7'h10: decode_seg = 5'h19;
      7'h08: decode_seg = 5'h1A;
      7'h03: decode_seg = 5'h1B;
      7'h46: decode_seg = 5'h1C;
      7'h21: decode_seg = 5'h1D;
      7'h06: decode_seg = 5'h1E;
      7'h0E: decode_seg = 5'h1F;
      default: decode_seg = 5'h00;
    endcase
  endfunction

  always_comb begin
    an_m_d        = anode;
    an_s_d        = an_m_q;
    ca_m_d        = cathode;
    ca_s_d        = ca_m_q;
    prev_d        = {an_s_q, ca_s_q};
    state_d       = state_q;
    mask_d        = mask_q;
    err_d         = err_q;
    buf_d         = buf_q;
    buf_dp_d      = buf_dp_q;
    encoded_d     = encoded_q;
    digit_point_d = digit_point_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
    error_count_d = error_count_q;

    changed    = ({an_s_q, ca_s_q} != prev_q);
    sel        = ~an_s_q;
    sel_single = (sel != '0) && ((sel & (sel - 1'b1)) == '0);
    dec        = decode_seg(ca_s_q[6:0]);

    if (changed)
      cnt_d = '0;
    else if (cnt_q == CNT_W'(SETTLE_CYCLES))
      cnt_d = cnt_q;
    else
      cnt_d = cnt_q + 1'b1;

    if (&mask_q) begin
      if (err_q) begin
        frame_error_d = 1'b1;
        if (error_count_q != 8'hFF)
          error_count_d = error_count_q + 8'd1;
      end else begin
        encoded_d     = buf_q;
        digit_point_d = buf_dp_q;
        frame_valid_d = 1'b1;
      end
      mask_d = '0;
      err_d  = 1'b0;
    end

    case (state_q)
      ST_WAIT: begin
        if (cnt_q == CNT_W'(SETTLE_CYCLES))
          state_d = ST_SAMPLE;
      end
      ST_SAMPLE: begin
        if (sel_single) begin
          for (int i = 0; i < NUM_SEGMENTS; i++) begin
            if (sel[i]) begin
              // A slot seen twice in one frame means a digit was missed.
              if (mask_q[i])
                err_d = 1'b1;
              mask_d[i]       = 1'b1;
              buf_d[i*4 +: 4] = dec[3:0];
              buf_dp_d[i]     = ~ca_s_q[7];
            end
          end
          if (!dec[4])
            err_d = 1'b1;
        end else if (sel != '0) begin
          err_d = 1'b1;
        end
        state_d = changed ? ST_WAIT : ST_HOLD;
      end
      ST_HOLD: begin
        if (changed)
          state_d = ST_WAIT;
      end
      default: state_d = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_WAIT;
      an_m_q        <= '1;
      an_s_q        <= '1;
      ca_m_q        <= '1;
      ca_s_q        <= '1;
      prev_q        <= '1;
      cnt_q         <= '0;
      mask_q        <= '0;
      err_q         <= 1'b0;
      buf_q         <= '0;
      buf_dp_q      <= '0;
      encoded_q     <= '0;
      digit_point_q <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
      error_count_q <= '0;
    end else begin
      state_q       <= state_d;
      an_m_q        <= an_m_d;
      an_s_q        <= an_s_d;
      ca_m_q        <= ca_m_d;
      ca_s_q        <= ca_s_d;
      prev_q        <= prev_d;
      cnt_q         <= cnt_d;
      mask_q        <= mask_d;
      err_q         <= err_d;
      buf_q         <= buf_d;
      buf_dp_q      <= buf_dp_d;
      encoded_q     <= encoded_d;
      digit_point_q <= digit_point_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
      error_count_q <= error_count_d;
    end
  end

  assign encoded     = encoded_q;
  assign digit_point = digit_point_q;
  assign frame_valid = frame_valid_q;
  assign frame_error = frame_error_q;
  assign error_count = error_count_q;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// tb_seven_segment_capture: directed bench for seven_segment_capture.
// Revision: 1.0
// ============================================================================
module tb_seven_segment_capture;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anode;
  logic [7:0]  cathode;
  logic [15:0] encoded;
  logic [3:0]  digit_point;
  logic        frame_valid;
  logic        frame_error;
  logic [7:0]  error_count;

  int n_cmp = 0;
  int n_bad = 0;
  int fv_cnt = 0;
  int fe_cnt = 0;
  int fv_base;
  int fe_base;

  localparam logic [6:0] S0 = 7'h40, S1 = 7'h79, S2 = 7'h24, S3 = 7'h30;
  localparam logic [6:0] S4 = 7'h19, S5 = 7'h12, S6 = 7'h02, S7 = 7'h78;
  localparam logic [6:0] S8 = 7'h00, S9 = 7'h10, SA = 7'h08, SB = 7'h03;
  localparam logic [6:0] SC = 7'h46, SD = 7'h21, SF = 7'h0E, SOFF = 7'h7F;

  seven_segment_capture #(
    .NUM_SEGMENTS(4),
    .CLK_PER     (10),
    .SETTLE_NS   (200)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .anode      (anode),
    .cathode    (cathode),
    .encoded    (encoded),
    .digit_point(digit_point),
    .frame_valid(frame_valid),
    .frame_error(frame_error),
    .error_count(error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pulse counters; the two pulses must never coincide.
  always @(negedge clk) begin
    if (frame_valid === 1'b1) fv_cnt++;
    if (frame_error === 1'b1) fe_cnt++;
    if (frame_valid === 1'b1 || frame_error === 1'b1)
      check("pulse_exclusive", {31'd0, frame_valid & frame_error}, 32'd0);
  end

  task automatic slot(input logic [3:0] an, input logic [7:0] ca, input int n);
    @(negedge clk);
    anode   = an;
    cathode = ca;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic digit(input int k, input logic [6:0] seg, input logic dp, input int n);
    logic [3:0] an;
    an = ~(4'b0001 << k);
    slot(an, {~dp, seg}, n);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                       input logic [6:0] s3, input logic [3:0] dp, input int n);
    digit(0, s0, dp[0], n);
    digit(1, s1, dp[1], n);
    digit(2, s2, dp[2], n);
    digit(3, s3, dp[3], n);
  endtask

  task automatic blank(input int n);
    slot(4'hF, 8'hFF, n);
  endtask

  initial begin
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 8'hFF;
    repeat (5) @(negedge clk);
    check("reset_encoded", {16'd0, encoded}, 32'h0);
    check("reset_dp", {28'd0, digit_point}, 32'h0);
    check("reset_fv", {31'd0, frame_valid}, 32'h0);
    check("reset_fe", {31'd0, frame_error}, 32'h0);
    check("reset_ec", {24'd0, error_count}, 32'h0);
    reset = 1'b0;
    blank(10);

    // Clean "12AF", no decimal points.
    fv_base = fv_cnt; fe_base = fe_cnt;
    scan4(S1, S2, SA, SF, 4'b0000, 100);
    blank(60);
    check("clean_fv", fv_cnt - fv_base, 1);
    check("clean_fe", fe_cnt - fe_base, 0);
    check("clean_encoded", {16'd0, encoded}, 32'hFA21);
    check("clean_dp", {28'd0, digit_point}, 32'h0);
    check("clean_ec", {24'd0, error_count}, 32'h0);

    // Decimal point on digit 2.
    fv_base = fv_cnt;
    scan4(S1, S2, SA, SF, 4'b0100, 100);
    blank(60);
    check("dp_fv", fv_cnt - fv_base, 1);
    check("dp_dp", {28'd0, digit_point}, 32'h4);
    check("dp_encoded", {16'd0, encoded}, 32'hFA21);

    // Unlit digit 1 is an undecodable pattern.
    fv_base = fv_cnt; fe_base = fe_cnt;
    scan4(S1, SOFF, SA, SF, 4'b0000, 100);
    blank(60);
    check("bad_fe", fe_cnt - fe_base, 1);
    check("bad_fv", fv_cnt - fv_base, 0);
    check("bad_encoded_hold", {16'd0, encoded}, 32'hFA21);
    check("bad_dp_hold", {28'd0, digit_point}, 32'h4);
    check("bad_ec", {24'd0, error_count}, 32'h1);

    fv_base = fv_cnt; fe_base = fe_cnt;
    scan4(S1, S2, SA, SF, 4'b0000, 100);
    blank(60);
    check("recover_fv", fv_cnt - fv_base, 1);
    check("recover_fe", fe_cnt - fe_base, 0);
    check("recover_dp", {28'd0, digit_point}, 32'h0);

    // Two anodes low at once, inserted mid-frame.
    fv_base = fv_cnt; fe_base = fe_cnt;
    digit(0, S1, 1'b0, 100);
    digit(1, S2, 1'b0, 100);
    slot(4'b1100, {1'b1, S8}, 100);
    digit(2, SA, 1'b0, 100);
    digit(3, SF, 1'b0, 100);
    blank(60);
    check("multi_fe", fe_cnt - fe_base, 1);
    check("multi_fv", fv_cnt - fv_base, 0);
    check("multi_ec", {24'd0, error_count}, 32'h2);

    // 300 errored frames: counter must saturate.
    fv_base = fv_cnt; fe_base = fe_cnt;
    for (int f = 0; f < 300; f++)
      scan4(S1, SOFF, SA, SF, 4'b0000, 30);
    blank(60);
    check("sat_fe", fe_cnt - fe_base, 300);
    check("sat_fv", fv_cnt - fv_base, 0);
    check("sat_ec", {24'd0, error_count}, 32'hFF);
    check("sat_encoded_hold", {16'd0, encoded}, 32'hFA21);

    // Cathode glitching on digit 0 must never be sampled.
    fv_base = fv_cnt; fe_base = fe_cnt;
    for (int g = 0; g < 10; g++)
      digit(0, (g % 2 == 0) ? SOFF : S3, 1'b0, 5);
    digit(0, S3, 1'b0, 100);
    digit(1, S4, 1'b0, 100);
    digit(2, S5, 1'b1, 100);
    digit(3, S6, 1'b0, 100);
    blank(60);
    check("glitch_fv", fv_cnt - fv_base, 1);
    check("glitch_fe", fe_cnt - fe_base, 0);
    check("glitch_encoded", {16'd0, encoded}, 32'h6543);
    check("glitch_dp", {28'd0, digit_point}, 32'h4);
    check("glitch_ec", {24'd0, error_count}, 32'hFF);

    // Reset after two of four slots.
    digit(0, S7, 1'b0, 100);
    digit(1, S8, 1'b0, 100);
    @(negedge clk);
    reset   = 1'b1;
    anode   = 4'hF;
    cathode = 8'hFF;
    repeat (3) @(negedge clk);
    check("midreset_encoded", {16'd0, encoded}, 32'h0);
    check("midreset_dp", {28'd0, digit_point}, 32'h0);
    check("midreset_ec", {24'd0, error_count}, 32'h0);
    reset = 1'b0;
    blank(10);
    fv_base = fv_cnt; fe_base = fe_cnt;
    scan4(S9, SB, SC, SD, 4'b1001, 100);
    blank(60);
    check("postreset_fv", fv_cnt - fv_base, 1);
    check("postreset_fe", fe_cnt - fe_base, 0);
    check("postreset_encoded", {16'd0, encoded}, 32'hDCB9);
    check("postreset_dp", {28'd0, digit_point}, 32'h9);
    check("postreset_ec", {24'd0, error_count}, 32'h0);

    // Remaining glyphs 0 and E, plus a repeated slot within one frame.
    fv_base = fv_cnt; fe_base = fe_cnt;
    scan4(S0, 7'h06, S0, 7'h06, 4'b0000, 40);
    blank(60);
    check("glyph_encoded", {16'd0, encoded}, 32'hE0E0);
    fv_base = fv_cnt; fe_base = fe_cnt;
    digit(0, S1, 1'b0, 40);
    digit(0, S2, 1'b0, 40);
    digit(1, S3, 1'b0, 40);
    digit(2, S4, 1'b0, 40);
    digit(3, S5, 1'b0, 40);
    blank(60);
    check("repeat_fe", fe_cnt - fe_base, 1);
    check("repeat_fv", fv_cnt - fv_base, 0);
    check("repeat_ec", {24'd0, error_count}, 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
